reg_scoreboard: RTL and testbench

Per-register pending-write scoreboard for the 4-stage pipeline (fetch, rf_read, execute, writeback). It records each register-writing instruction as it issues from rf_read into execute and releases it when it retires in writeback or is flushed. It raises a stall whenever the instruction in rf_read sources a register whose value neither the register file nor the writeback forwarding path can supply this cycle. It is the producer-tracking counterpart to the writeback-hazard forwarding detector.

---
 rtl/reg_scoreboard.sv | 231 +++++++++++++++++++++++
 tb/tb_reg_scoreboard.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write scoreboard for a 4-stage pipeline
//               (fetch, rf_read, execute, writeback). Counts in-flight writes
//               to each of 8 registers, releases them on retire or flush, and
//               stalls rf_read when a source register has a producer in
//               flight that the writeback forwarding path cannot cover.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_issue_valid,
    input  logic [15:0] i_issue_ir,
    input  logic        i_retire_valid,
    input  logic [15:0] i_retire_ir,
    input  logic        i_flush_valid,
    input  logic [15:0] i_flush_ir,
    input  logic [15:0] i_rf_ir,
    output logic        o_stall,
    output logic [7:0]  o_busy_mask,
    output logic [2:0]  o_inflight,
    output logic        o_error
);

    // ------------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_OP_MV   = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_CMP  = 4'h3;
    localparam logic [3:0] c_OP_LD   = 4'h4;
    localparam logic [3:0] c_OP_ST   = 4'h5;
    localparam logic [3:0] c_OP_MVHI = 4'h6;
    localparam logic [3:0] c_OP_J    = 4'h8;
    localparam logic [3:0] c_OP_JZ   = 4'h9;
    localparam logic [3:0] c_OP_JN   = 4'hA;
    localparam logic [3:0] c_OP_CALL = 4'hC;

    localparam int         c_NUM_REGS = 8;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------

    // True when the opcode writes its Rx field.
    function automatic logic f_is_writer(input logic [3:0] op);
        logic v_wr;
        case (op)
            c_OP_MV, c_OP_ADD, c_OP_SUB, c_OP_LD, c_OP_MVHI: v_wr = 1'b1;
            default:                                         v_wr = 1'b0;
        endcase
        return v_wr;
    endfunction

    // One-hot register select.
    function automatic logic [7:0] f_onehot(input logic [2:0] idx);
        logic [7:0] v_oh;
        v_oh      = 8'h00;
        v_oh[idx] = 1'b1;
        return v_oh;
    endfunction

    // Set of registers read by an instruction, as a bit mask.
    function automatic logic [7:0] f_src_mask(
        input logic [3:0] op,
        input logic       imm,
        input logic [2:0] rx,
        input logic [2:0] ry
    );
        logic [7:0] v_m;
        v_m = 8'h00;
        case (op)
            c_OP_MV: begin
                if (!imm) v_m = f_onehot(ry);
            end
            c_OP_ADD, c_OP_SUB, c_OP_CMP: begin
                v_m = f_onehot(rx);
                if (!imm) v_m = v_m | f_onehot(ry);
            end
            c_OP_LD: begin
                v_m = f_onehot(ry);
            end
            c_OP_ST: begin
                v_m = f_onehot(rx) | f_onehot(ry);
            end
            c_OP_MVHI: begin
                v_m = f_onehot(rx);
            end
            c_OP_J, c_OP_JZ, c_OP_JN, c_OP_CALL: begin
                if (!imm) v_m = f_onehot(rx);
            end
            default: begin
                v_m = 8'h00;
            end
        endcase
        return v_m;
    endfunction

    // ------------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------------
    logic [3:0] w_iss_op;
    logic [2:0] w_iss_rx;
    logic [3:0] w_ret_op;
    logic [2:0] w_ret_rx;
    logic [3:0] w_flu_op;
    logic [2:0] w_flu_rx;
    logic [3:0] w_rf_op;
    logic       w_rf_imm;
    logic [2:0] w_rf_rx;
    logic [2:0] w_rf_ry;

    assign w_iss_op = i_issue_ir[3:0];
    assign w_iss_rx = i_issue_ir[7:5];
    assign w_ret_op = i_retire_ir[3:0];
    assign w_ret_rx = i_retire_ir[7:5];
    assign w_flu_op = i_flush_ir[3:0];
    assign w_flu_rx = i_flush_ir[7:5];
    assign w_rf_op  = i_rf_ir[3:0];
    assign w_rf_imm = i_rf_ir[4];
    assign w_rf_rx  = i_rf_ir[7:5];
    assign w_rf_ry  = i_rf_ir[10:8];

    // Fields that play no part in scoreboarding.
    logic w_unused;
    assign w_unused = &{1'b0, i_issue_ir[15:8], i_issue_ir[4],
                        i_retire_ir[15:8], i_retire_ir[4],
                        i_flush_ir[15:8], i_flush_ir[4], i_rf_ir[15:11]};

    // ------------------------------------------------------------------------
    // Per-register increment / decrement requests
    // ------------------------------------------------------------------------
    logic [7:0] w_inc;
    logic [7:0] w_dec_ret;
    logic [7:0] w_dec_flu;
    logic [7:0] w_src;

    assign w_inc     = (i_issue_valid  && f_is_writer(w_iss_op)) ? f_onehot(w_iss_rx) : 8'h00;
    assign w_dec_ret = (i_retire_valid && f_is_writer(w_ret_op)) ? f_onehot(w_ret_rx) : 8'h00;
    assign w_dec_flu = (i_flush_valid  && f_is_writer(w_flu_op)) ? f_onehot(w_flu_rx) : 8'h00;
    assign w_src     = f_src_mask(w_rf_op, w_rf_imm, w_rf_rx, w_rf_ry);

    // ------------------------------------------------------------------------
    // Counter state and per-register next-value logic
    // ------------------------------------------------------------------------
    logic [7:0][1:0] r_count;
    logic [7:0][1:0] w_next;
    logic [7:0]      w_ovf;
    logic [7:0]      w_unf;
    logic [7:0]      w_busy_now;
    logic [7:0]      w_busy_next;

    for (genvar g = 0; g < c_NUM_REGS; g++) begin : g_reg
        logic [2:0] w_up;
        logic [2:0] w_dn;
        logic [1:0] w_diff;

        // count + inc spans 0..4 and dec spans 0..2, so 3 bits cover both.
        assign w_up   = {1'b0, r_count[g]} + {2'b00, w_inc[g]};
        assign w_dn   = {2'b00, w_dec_ret[g]} + {2'b00, w_dec_flu[g]};
        // Modulo-4 difference is exact whenever neither bound is crossed.
        assign w_diff = w_up[1:0] - w_dn[1:0];

        assign w_ovf[g]  = (w_up > (w_dn + 3'd3));
        assign w_unf[g]  = (w_up < w_dn);
        assign w_next[g] = w_ovf[g] ? r_count[g] :
                           (w_unf[g] ? 2'd0 : w_diff);

        assign w_busy_next[g] = (w_next[g] != 2'd0);

        // A lone producer retiring this cycle is forwardable from writeback;
        // a flush offers no such path.
        assign w_busy_now[g] = (r_count[g] != 2'd0) &&
                               !((r_count[g] == 2'd1) && w_dec_ret[g]);
    end

    // ------------------------------------------------------------------------
    // Pending-write total for the next state
    // ------------------------------------------------------------------------
    logic [4:0] w_sum;
    logic [2:0] w_inflight_next;

    // Add up all next-state counters.
    always_comb begin
        w_sum = 5'd0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_sum = w_sum + {3'b000, w_next[i]};
        end
    end

    // Pipeline depth keeps the total at or below 6; clamp anyway so the
    // output never wraps if misused.
    assign w_inflight_next = (w_sum > 5'd7) ? 3'd7 : w_sum[2:0];

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [7:0] r_busy_mask;
    logic [2:0] r_inflight;
    logic       r_error;

    // Counters, registered summaries and sticky error; reset dominates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count     <= '0;
            r_busy_mask <= 8'h00;
            r_inflight  <= 3'd0;
            r_error     <= 1'b0;
        end else begin
            r_count     <= w_next;
            r_busy_mask <= w_busy_next;
            r_inflight  <= w_inflight_next;
            if (|(w_ovf | w_unf)) begin
                r_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_stall     = |(w_src & w_busy_now);
    assign o_busy_mask = r_busy_mask;
    assign o_inflight  = r_inflight;
    assign o_error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk;
    logic        reset;
    logic        i_issue_valid;
    logic [15:0] i_issue_ir;
    logic        i_retire_valid;
    logic [15:0] i_retire_ir;
    logic        i_flush_valid;
    logic [15:0] i_flush_ir;
    logic [15:0] i_rf_ir;
    logic        o_stall;
    logic [7:0]  o_busy_mask;
    logic [2:0]  o_inflight;
    logic        o_error;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: plain integer pending-write counts.
    int m_cnt [8];
    bit m_err;

    reg_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .i_issue_valid  (i_issue_valid),
        .i_issue_ir     (i_issue_ir),
        .i_retire_valid (i_retire_valid),
        .i_retire_ir    (i_retire_ir),
        .i_flush_valid  (i_flush_valid),
        .i_flush_ir     (i_flush_ir),
        .i_rf_ir        (i_rf_ir),
        .o_stall        (o_stall),
        .o_busy_mask    (o_busy_mask),
        .o_inflight     (o_inflight),
        .o_error        (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_writer(input logic [15:0] ir);
        int op;
        op = int'(ir[3:0]);
        return (op == 0) || (op == 1) || (op == 2) || (op == 4) || (op == 6);
    endfunction

    function automatic bit [7:0] m_srcs(input logic [15:0] ir);
        bit [7:0] s;
        int op, rx, ry;
        bit imm;
        op  = int'(ir[3:0]);
        imm = ir[4];
        rx  = int'(ir[7:5]);
        ry  = int'(ir[10:8]);
        s   = 8'h00;
        case (op)
            0:          if (!imm) s[ry] = 1'b1;
            1, 2, 3:    begin s[rx] = 1'b1; if (!imm) s[ry] = 1'b1; end
            4:          s[ry] = 1'b1;
            5:          begin s[rx] = 1'b1; s[ry] = 1'b1; end
            6:          s[rx] = 1'b1;
            8, 9, 10, 12: if (!imm) s[rx] = 1'b1;
            default:    s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic bit m_stall();
        bit [7:0] s;
        bit st;
        s  = m_srcs(i_rf_ir);
        st = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (s[r] && m_cnt[r] != 0) begin
                if (!(m_cnt[r] == 1 && i_retire_valid && m_writer(i_retire_ir) &&
                      int'(i_retire_ir[7:5]) == r))
                    st = 1'b1;
            end
        end
        return st;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        for (int r = 0; r < 8; r++) m[r] = (m_cnt[r] != 0);
        return m;
    endfunction

    function automatic int m_sum();
        int s;
        s = 0;
        for (int r = 0; r < 8; r++) s += m_cnt[r];
        return s;
    endfunction

    function automatic logic [2:0] m_inflight();
        int s;
        s = m_sum();
        if (s > 7) s = 7;
        return 3'(s);
    endfunction

    // Apply one clock edge worth of events to the model.
    task automatic m_update();
        int inc, dec, n;
        if (!reset) begin
            for (int r = 0; r < 8; r++) m_cnt[r] = 0;
            m_err = 1'b0;
            return;
        end
        for (int r = 0; r < 8; r++) begin
            inc = (i_issue_valid && m_writer(i_issue_ir) && int'(i_issue_ir[7:5]) == r) ? 1 : 0;
            dec = ((i_retire_valid && m_writer(i_retire_ir) && int'(i_retire_ir[7:5]) == r) ? 1 : 0)
                + ((i_flush_valid && m_writer(i_flush_ir) && int'(i_flush_ir[7:5]) == r) ? 1 : 0);
            n = m_cnt[r] + inc - dec;
            if (n > 3) m_err = 1'b1;
            else if (n < 0) begin m_cnt[r] = 0; m_err = 1'b1; end
            else m_cnt[r] = n;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        i_issue_valid  = 1'b0; i_issue_ir  = 16'h0;
        i_retire_valid = 1'b0; i_retire_ir = 16'h0;
        i_flush_valid  = 1'b0; i_flush_ir  = 16'h0;
    endtask

    // Inputs are set after a falling edge; this commits them at the next
    // rising edge and returns at the following falling edge.
    task automatic tick();
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
        i_retire_valid = 1'b0; i_flush_valid = 1'b0;
        i_rf_ir = 16'h0221;
        tick();
        tick();
        reset = 1'b1;
        set_idle();
        i_rf_ir = 16'h0221;
        #1;
        checks++; if (o_busy_mask !== 8'h00) begin errors++; $display("FAIL reset_mask got=%h exp=00", o_busy_mask); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", o_inflight); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", o_error); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    endtask

    task automatic test_load_use();
        set_idle();
        i_issue_valid = 1'b1; i_issue_ir = 16'h0164;
        i_rf_ir = 16'h0000;
        tick();
        set_idle();
        i_rf_ir = 16'h0381;
        #1;
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", o_stall); end
        checks++; if (o_busy_mask !== 8'h08) begin errors++; $display("FAIL lu_mask got=%h exp=08", o_busy_mask); end
        checks++; if (o_inflight !== 3'd1) begin errors++; $display("FAIL lu_inflight got=%0d exp=1", o_inflight); end
        tick();
        i_retire_valid = 1'b1; i_retire_ir = 16'h0164;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_retire_stall got=%b exp=0", o_stall); end
        checks++; if (o_busy_mask !== 8'h08) begin errors++; $display("FAIL lu_retire_mask got=%h exp=08", o_busy_mask); end
        tick();
        set_idle();
        #1;
        checks++; if (o_busy_mask !== 8'h00) begin errors++; $display("FAIL lu_after_mask got=%h exp=00", o_busy_mask); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_after_stall got=%b exp=0", o_stall); end
    endtask

    task automatic test_immediate();
        set_idle();
        i_issue_valid = 1'b1; i_issue_ir = 16'h0164;
        tick();
        set_idle();
        i_rf_ir = 16'h0370;
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL imm1_stall got=%b exp=0", o_stall); end
        i_rf_ir = 16'h0360;
        #1;
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL imm0_stall got=%b exp=1", o_stall); end
        i_retire_valid = 1'b1; i_retire_ir = 16'h0164;
        tick();
        set_idle();
        #1;
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL imm_clean got=%0d exp=0", o_inflight); end
    endtask

    task automatic test_simultaneous();
        set_idle();
        i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
        tick();
        i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
        i_retire_valid = 1'b1; i_retire_ir = 16'h0221;
        tick();
        set_idle();
        #1;
        checks++; if (o_busy_mask !== 8'h02) begin errors++; $display("FAIL sim_mask got=%h exp=02", o_busy_mask); end
        checks++; if (o_inflight !== 3'd1) begin errors++; $display("FAIL sim_inflight got=%0d exp=1", o_inflight); end
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL sim_error got=%b exp=0", o_error); end
        i_retire_valid = 1'b1; i_retire_ir = 16'h0221;
        tick();
        set_idle();
        #1;
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL sim_clean got=%0d exp=0", o_inflight); end
    endtask

    task automatic test_flush();
        set_idle();
        i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
        i_rf_ir = 16'h0000;
        tick();
        set_idle();
        i_flush_valid = 1'b1; i_flush_ir = 16'h0221;
        i_rf_ir = 16'h0321;
        #1;
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b exp=1", o_stall); end
        tick();
        set_idle();
        #1;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall got=%b exp=0", o_stall); end
        checks++; if (o_inflight !== 3'd0) begin errors++; $display("FAIL flush_inflight got=%0d exp=0", o_inflight); end
    endtask

    task automatic test_errors();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
            tick();
        end
        set_idle();
        #1;
        checks++; if (o_inflight !== 3'd3 || o_error !== 1'b0) begin errors++; $display("FAIL ovf_pre got=%0d/%b exp=3/0", o_inflight, o_error); end
        i_issue_valid = 1'b1; i_issue_ir = 16'h0221;
        tick();
        set_idle();
        #1;
        checks++; if (o_inflight !== 3'd3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", o_inflight); end
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%b exp=1", o_error); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (o_error !== 1'b0 || o_inflight !== 3'd0) begin errors++; $display("FAIL ovf_reset got=%b/%0d exp=0/0", o_error, o_inflight); end
        i_retire_valid = 1'b1; i_retire_ir = 16'h0221;
        tick();
        set_idle();
        #1;
        checks++; if (o_busy_mask !== 8'h00 || o_inflight !== 3'd0) begin errors++; $display("FAIL unf_count got=%h/%0d exp=00/0", o_busy_mask, o_inflight); end
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL unf_error got=%b exp=1", o_error); end
        tick(); tick(); tick();
        #1;
        checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL unf_sticky got=%b exp=1", o_error); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", o_error); end
    endtask

    // Random writer IR targeting a random register.
    function automatic logic [15:0] rand_writer();
        logic [15:0] ir;
        logic [3:0]  ops [5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h4; ops[4] = 4'h6;
        ir = 16'($urandom);
        ir[3:0] = ops[$urandom_range(0, 4)];
        return ir;
    endfunction

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_idle();
            reset = ((cyc % 97) == 96) ? 1'b0 : 1'b1;
            if (m_sum() < 6 && $urandom_range(0, 1) == 1) begin
                i_issue_valid = 1'b1;
                i_issue_ir = ($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_writer();
            end
            if ($urandom_range(0, 2) == 0) begin
                i_retire_valid = 1'b1;
                i_retire_ir = ($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_writer();
            end
            if ($urandom_range(0, 5) == 0) begin
                i_flush_valid = 1'b1;
                i_flush_ir = rand_writer();
            end
            i_rf_ir = 16'($urandom);
            #1;
            checks++; if (o_stall !== m_stall()) begin errors++; $display("FAIL rnd_stall cyc=%0d rf=%h got=%b exp=%b", cyc, i_rf_ir, o_stall, m_stall()); end
            checks++; if (o_busy_mask !== m_mask()) begin errors++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", cyc, o_busy_mask, m_mask()); end
            checks++; if (o_inflight !== m_inflight()) begin errors++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, o_inflight, m_inflight()); end
            checks++; if (o_error !== m_err) begin errors++; $display("FAIL rnd_error cyc=%0d got=%b exp=%b", cyc, o_error, m_err); end
            tick();
        end
        reset = 1'b1;
        set_idle();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        i_rf_ir = 16'h0;
        for (int r = 0; r < 8; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_immediate();
        test_simultaneous();
        test_flush();
        test_errors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
